// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
//   Registered execute stage in front of a 32-bit combinational barrel shifter.
//   Accepts decoded shift requests over valid/ready and resolves the amount
//   source (immediate or register). It clamps the amount to 0..32 and holds
//   the request in a capture register that drives the shifter. Results go into
//   a small in-order FIFO for writeback.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   in_valid / in_ready : request handshake from issue
//   in_op               : 00 SLL, 01 SRL, 10 SRA, 11 illegal
//   in_a, in_b, in_imm  : operand, register amount source (bits [5:0]), imm
//   in_use_imm          : 1 selects in_imm, 0 selects in_b[5:0]
//   in_tag              : destination tag carried to the result
//   bs_in/bs_shift/bs_selector -> barrel shifter, bs_out <- barrel shifter
//   out_valid/out_ready : result handshake toward writeback
//   out_data/out_tag/out_err : head-of-FIFO result fields
// -----------------------------------------------------------------------------
module shift_exec_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_use_imm,
  input  logic [5:0]  in_imm,
  input  logic [3:0]  in_tag,
  output logic [31:0] bs_in,
  output logic [5:0]  bs_shift,
  output logic [1:0]  bs_selector,
  input  logic [31:0] bs_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_tag,
  output logic        out_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Capture register
  logic          cap_valid_q, cap_valid_d;
  logic [31:0]   cap_a_q,     cap_a_d;
  logic [5:0]    cap_amt_q,   cap_amt_d;
  logic [1:0]    cap_op_q,    cap_op_d;
  logic [3:0]    cap_tag_q,   cap_tag_d;

  // Result FIFO
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_d [FIFO_DEPTH];
  logic [3:0]    fifo_tag_q  [FIFO_DEPTH];
  logic [3:0]    fifo_tag_d  [FIFO_DEPTH];
  logic          fifo_err_q  [FIFO_DEPTH];
  logic          fifo_err_d  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          pop_s, push_s, full_s, advance_s, accept_s, illegal_s;
  logic [5:0]    raw_amt_s, clamp_amt_s;
  logic [31:0]   result_s;
  logic          unused_b_s;

  // Only the low six bits of the register source carry an amount.
  assign unused_b_s = ^in_b[31:6];

  // Handshake, advance and shifter-drive decode.
  always_comb begin
    full_s    = (count_q == DEPTH_C);
    pop_s     = (count_q != {CW{1'b0}}) && out_ready;
    // A pop frees the slot this cycle, so a full FIFO can still take a push.
    advance_s = cap_valid_q && (!full_s || pop_s);
    push_s    = advance_s;
    in_ready  = !cap_valid_q || advance_s;
    accept_s  = in_valid && in_ready;

    raw_amt_s   = in_use_imm ? in_imm : in_b[5:0];
    // Amounts 33..63 would hit the shifter's pass-through default.
    clamp_amt_s = (raw_amt_s > 6'd32) ? 6'd32 : raw_amt_s;

    illegal_s = (cap_op_q == 2'b11);
    bs_in     = cap_a_q;
    if (cap_valid_q && !illegal_s) begin
      bs_shift    = cap_amt_q;
      bs_selector = cap_op_q;
    end else begin
      bs_shift    = 6'd0;
      bs_selector = 2'b11;
    end
    result_s = illegal_s ? cap_a_q : bs_out;

    out_valid = (count_q != {CW{1'b0}});
    out_data  = fifo_data_q[rd_ptr_q];
    out_tag   = fifo_tag_q[rd_ptr_q];
    out_err   = fifo_err_q[rd_ptr_q];
  end

  // Next-state for capture register and FIFO.
  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_a_d     = cap_a_q;
    cap_amt_d   = cap_amt_q;
    cap_op_d    = cap_op_q;
    cap_tag_d   = cap_tag_q;
    fifo_data_d = fifo_data_q;
    fifo_tag_d  = fifo_tag_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (accept_s) begin
      cap_valid_d = 1'b1;
      cap_a_d     = in_a;
      cap_amt_d   = clamp_amt_s;
      cap_op_d    = in_op;
      cap_tag_d   = in_tag;
    end else if (advance_s) begin
      cap_valid_d = 1'b0;
    end else begin
      cap_valid_d = cap_valid_q;
    end

    if (push_s) begin
      fifo_data_d[wr_ptr_q] = result_s;
      fifo_tag_d[wr_ptr_q]  = cap_tag_q;
      fifo_err_d[wr_ptr_q]  = illegal_s;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_a_q     <= 32'd0;
      cap_amt_q   <= 6'd0;
      cap_op_q    <= 2'b00;
      cap_tag_q   <= 4'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= 32'd0;
        fifo_tag_q[i]  <= 4'd0;
        fifo_err_q[i]  <= 1'b0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_a_q     <= cap_a_d;
      cap_amt_q   <= cap_amt_d;
      cap_op_q    <= cap_op_d;
      cap_tag_q   <= cap_tag_d;
      fifo_data_q <= fifo_data_d;
      fifo_tag_q  <= fifo_tag_d;
      fifo_err_q  <= fifo_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_exec_stage
//   Directed self-checking bench for shift_exec_stage. A behavioural barrel
//   shifter model answers the DUT's bs_* drive. Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_use_imm;
  logic [5:0]  in_imm;
  logic [3:0]  in_tag;
  logic [31:0] bs_in;
  logic [5:0]  bs_shift;
  logic [1:0]  bs_selector;
  logic [31:0] bs_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;

  int checks   = 0;
  int failures = 0;

  shift_exec_stage #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_tag(in_tag),
    .bs_in(bs_in), .bs_shift(bs_shift), .bs_selector(bs_selector),
    .bs_out(bs_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Barrel shifter model: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
  always_comb begin
    case (bs_selector)
      2'b00:   bs_out = bs_in << bs_shift;
      2'b01:   bs_out = bs_in >> bs_shift;
      2'b10:   bs_out = $unsigned($signed(bs_in) >>> bs_shift);
      default: bs_out = bs_in;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_imm,
                         input logic [5:0] imm, input logic [3:0] tag);
    in_op      = op;
    in_a       = a;
    in_b       = b;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_tag     = tag;
  endtask

  // One request with an empty pipe and out_ready=1; checks drive and latency.
  task automatic do_one(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic use_imm, input logic [5:0] imm,
                        input logic [3:0] tag, input logic [5:0] exp_shift,
                        input logic [1:0] exp_sel, input logic [31:0] exp_data,
                        input logic exp_err);
    set_req(op, a, b, use_imm, imm, tag);
    in_valid = 1'b1;
    #1;
    chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({name, ".bs_in"}, bs_in, a);
    chk({name, ".bs_shift"}, 32'(bs_shift), 32'(exp_shift));
    chk({name, ".bs_sel"}, 32'(bs_selector), 32'(exp_sel));
    chk({name, ".early_valid"}, 32'(out_valid), 32'd0);
    step();
    chk({name, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({name, ".out_data"}, out_data, exp_data);
    chk({name, ".out_tag"}, 32'(out_tag), 32'(tag));
    chk({name, ".out_err"}, 32'(out_err), 32'(exp_err));
    step();
    chk({name, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int stale;
    int wait_cnt;
    logic [3:0] exp_tags [4];
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_req(2'b00, 32'd0, 32'd0, 1'b0, 6'd0, 4'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.out_tag", 32'(out_tag), 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.bs_in", bs_in, 32'd0);
    chk("rst.bs_shift", 32'(bs_shift), 32'd0);
    chk("rst.bs_sel", 32'(bs_selector), 32'd3);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    do_one("sll_imm", 2'b00, 32'h0000_0001, 32'h0000_0007, 1'b1, 6'd4, 4'h5,
           6'd4, 2'b00, 32'h0000_0010, 1'b0);
    do_one("sra_31", 2'b10, 32'h8000_0000, 32'h0000_001F, 1'b0, 6'd5, 4'h6,
           6'd31, 2'b10, 32'hFFFF_FFFF, 1'b0);
    do_one("sra_32", 2'b10, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 6'd32, 4'h7,
           6'd32, 2'b10, 32'h0000_0000, 1'b0);
    do_one("srl_clamp", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FF28, 1'b0, 6'd1, 4'h8,
           6'd32, 2'b01, 32'h0000_0000, 1'b0);
    do_one("sll_clamp", 2'b00, 32'h1234_5678, 32'h0000_0000, 1'b1, 6'd63, 4'h9,
           6'd32, 2'b00, 32'h0000_0000, 1'b0);
    do_one("illegal", 2'b11, 32'hDEAD_BEEF, 32'h0000_0004, 1'b0, 6'd0, 4'hA,
           6'd0, 2'b11, 32'hDEAD_BEEF, 1'b1);

    // Backpressure: tags 1..4, SLL a=t by t -> 2, 8, 24, 64.
    out_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      set_req(2'b00, 32'(t), 32'd0, 1'b1, 6'(t), 4'(t));
      in_valid = 1'b1;
      #1;
      chk($sformatf("bp.ready_t%0d", t), 32'(in_ready), (t <= 3) ? 32'd1 : 32'd0);
      if (t <= 3) begin
        step();
      end else begin
        #0;
      end
    end
    step();
    chk("bp.still_stalled", 32'(in_ready), 32'd0);
    chk("bp.head_tag", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp.ready_on_pop", 32'(in_ready), 32'd1);
    chk("bp.data1", out_data, 32'd2);
    step();
    in_valid = 1'b0;
    chk("bp.count_full_pushpop", 32'(dut.count_q), 32'd2);
    exp_tags = '{4'd2, 4'd3, 4'd4, 4'd0};
    for (int k = 0; k < 3; k++) begin
      wait_cnt = 0;
      while (!out_valid && wait_cnt < 5) begin
        step();
        wait_cnt++;
      end
      chk($sformatf("bp.valid_%0d", k + 2), 32'(out_valid), 32'd1);
      chk($sformatf("bp.tag_%0d", k + 2), 32'(out_tag), 32'(exp_tags[k]));
      chk($sformatf("bp.data_%0d", k + 2), out_data,
          32'(exp_tags[k]) << exp_tags[k]);
      step();
    end
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Reset mid-stream: two queued results plus one captured.
    out_ready = 1'b0;
    for (int t = 9; t <= 11; t++) begin
      set_req(2'b01, 32'hF000_0000, 32'd0, 1'b1, 6'd4, 4'(t));
      in_valid = 1'b1;
      step();
    end
    chk("rs.stalled", 32'(in_ready), 32'd0);
    chk("rs.queued", 32'(out_valid), 32'd1);
    set_req(2'b00, 32'h1, 32'd0, 1'b1, 6'd1, 4'hC);
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rs.out_valid", 32'(out_valid), 32'd0);
    chk("rs.in_ready", 32'(in_ready), 32'd1);
    chk("rs.bs_sel", 32'(bs_selector), 32'd3);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) stale++;
    end
    chk("rs.no_stale", 32'(stale), 32'd0);
    do_one("post_rst", 2'b01, 32'h8000_0000, 32'h0000_0003, 1'b0, 6'd0, 4'hE,
           6'd3, 2'b01, 32'h1000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Registered execute stage that issues shift operations to the 32-bit combinational barrel shifter and buffers its results. It accepts decoded shift requests from the issue logic over a valid/ready handshake and resolves the shift-amount source. It clamps the shift amount, drives the shifter's `in`/`shift`/`selector` inputs from a capture register, and queues results in a small output FIFO for writeback. This gives a one-per-cycle throughput with backpressure toward issue.

## Interface
- `FIFO_DEPTH`, default 2: result FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  stage can accept request this cycle.
- `in_op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 illegal.
- `in_a`  in  32  operand to shift.
- `in_b`  in  32  register shift source; bits [5:0] used.
- `in_use_imm`  in  1  1: amount from `in_imm`, 0: from `in_b[5:0]`.
- `in_imm`  in  6  immediate shift amount.
- `in_tag`  in  4  destination tag, carried unchanged.
- `bs_in`  out  32  to barrel shifter `in`.
- `bs_shift`  out  6  to barrel shifter `shift`, always 0..32.
- `bs_selector`  out  2  to barrel shifter `selector`.
- `bs_out`  in  32  barrel shifter result.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  32  result.
- `out_tag`  out  4  tag of result.
- `out_err`  out  1  result came from illegal op.

## Operation
- Amount resolution at accept: raw = `in_use_imm` ? `in_imm` : `in_b[5:0]`; stored amount = (raw > 32) ? 32 : raw. This prevents the shifter's pass-through default for 33..63.
- Capture register holds a, amount, op, tag, and `cap_valid`. `bs_in`=a, `bs_shift`=amount, `bs_selector`=op when valid. When the op is illegal or the register is empty, drive `bs_selector`=11 and `bs_shift`=0.
- Illegal op (11): result = captured a, err=1. Legal: result = `bs_out`, err=0.
- advance = `cap_valid` && (FIFO not full || pop this cycle). On advance, {result, tag, err} is pushed to FIFO.
- Capture register loads on accept (`in_valid && in_ready`). It clears when advance occurs with no accept.
- `in_ready` = !`cap_valid` || advance (combinational from FIFO state and `out_ready`).
- FIFO: write/read pointers of log2(`FIFO_DEPTH`) bits wrap modulo depth; count 0..`FIFO_DEPTH`.
  - pop = `out_valid && out_ready`.
  - Push and pop in the same cycle leave count unchanged. This is legal when full (pop frees the slot) and when count=1.
  - Push never occurs while full without a pop; pop never occurs while empty.
- `out_valid` = count≠0; `out_data`/`out_tag`/`out_err` come from the head entry. Outputs are registered state, with no combinational path from `in_*`.
- Order is strictly preserved; tags are never reordered or dropped.

## Timing
- Reset (synchronous): `cap_valid`=0, count=0, pointers=0, all FIFO entries and capture fields=0.
  - After the reset edge: `out_valid`=0, `out_data`=0, `out_tag`=0, `out_err`=0, `bs_in`=0, `bs_shift`=0, `bs_selector`=11, `in_ready`=1.
- Reset asserted mid-operation discards the capture register and all FIFO contents. The handshake on a reset cycle is ignored; no accept or pop takes effect.
- Latency: request accepted at edge N gives `out_valid` for it in the cycle after edge N+1 (2 cycles), provided the FIFO is not full.
- Throughput: 1 request/cycle sustained with `out_ready`=1.
- With `out_ready` held 0: at most `FIFO_DEPTH`+1 requests are accepted, then `in_ready`=0. When `out_ready` rises, `in_ready` returns to 1 in the same cycle.
- Request fields are sampled only at accept; `in_*` may change freely when not accepted.

## Test plan
- SLL: a=0x0000_0001, imm=4, use_imm=1 → out_data=0x0000_0010, err=0, tag echoed, out_valid 2 cycles after accept.
- SRA: a=0x8000_0000, b[5:0]=31 → 0xFFFF_FFFF; then SRA a=0x7FFF_FFFF, amount 32 → 0x0000_0000.
- Clamp: SRL a=0xFFFF_FFFF, b[5:0]=40 → bs_shift=32, out_data=0; SLL a=0x1234_5678, imm=63 → 0.
- Backpressure (`FIFO_DEPTH`=2): out_ready=0, offer tags 1..4 back-to-back → 3 accepted, in_ready=0 on 4th. Raise out_ready → tags emerge 1,2,3,4 in order with correct data. Check simultaneous push/pop while full keeps count=2.
- Illegal op 11: a=0xDEAD_BEEF → out_data=0xDEAD_BEEF, out_err=1.
- Reset mid-stream: 2 results queued plus 1 captured, assert rst one cycle → out_valid=0, in_ready=1, no stale result ever emitted afterward.
